// File: rtl/lfsr_checker_pkg.sv
// Shared LFSR definitions used by the pattern generator and the receive-side checker.
package lfsr_checker_pkg;

  localparam logic [7:0] POLY_DEFAULT = 8'b1011_1000;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Fibonacci step: shift left, feedback bit is the parity of the tapped bits.
  function automatic logic [7:0] lfsr_step(input logic [7:0] x, input logic [7:0] poly);
    return {x[6:0], ^(x & poly)};
  endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// Count is registered: an increment sampled at edge N is visible after edge N.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// LFSR stream checker: self-seeds from received words, locks after LOCK_CNT matches, counts errors.
// One-cycle registered response to every valid word; no backpressure, a word is accepted whenever in_valid is high.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter logic [7:0]  POLY       = POLY_DEFAULT,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [7:0]       expected,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

  chk_state_t state, state_nxt;
  logic [7:0] expected_nxt;
  logic [3:0] match_cnt, match_nxt;
  logic [3:0] miss_cnt, miss_nxt;
  logic       locked_nxt;
  logic       err_nxt;
  logic       err_inc;
  logic       word_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      expected  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      expected  <= expected_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      locked    <= locked_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    expected_nxt = expected;
    match_nxt    = match_cnt;
    miss_nxt     = miss_cnt;
    locked_nxt   = locked;
    err_nxt      = 1'b0;
    err_inc      = 1'b0;
    word_inc     = 1'b0;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          // The all-zero word is the LFSR lock-up state and can never seed a valid sequence.
          if (in_data != 8'h00) begin
            expected_nxt = lfsr_step(in_data, POLY);
            match_nxt    = '0;
            state_nxt    = VERIFY;
          end
        end
        VERIFY: begin
          if (in_data == expected) begin
            expected_nxt = lfsr_step(in_data, POLY);
            match_nxt    = match_cnt + 4'd1;
            if (match_cnt + 4'd1 == LOCK_N) begin
              state_nxt  = LOCKED;
              locked_nxt = 1'b1;
              miss_nxt   = '0;
            end
          end else if (in_data != 8'h00) begin
            expected_nxt = lfsr_step(in_data, POLY);
            match_nxt    = '0;
          end else begin
            state_nxt    = HUNT;
            expected_nxt = '0;
          end
        end
        LOCKED: begin
          word_inc = 1'b1;
          // Freewheel on the prediction so a single corrupted word costs exactly one error.
          expected_nxt = lfsr_step(expected, POLY);
          if (in_data == expected) begin
            miss_nxt = '0;
          end else begin
            err_nxt  = 1'b1;
            err_inc  = 1'b1;
            miss_nxt = miss_cnt + 4'd1;
            if (miss_cnt + 4'd1 == UNLOCK_N) begin
              state_nxt    = HUNT;
              locked_nxt   = 1'b0;
              expected_nxt = '0;
            end
          end
        end
        default: begin
          state_nxt    = HUNT;
          locked_nxt   = 1'b0;
          expected_nxt = '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_err_count (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .clr   (clr),
    .count (err_count)
  );

  sat_counter #(.W(CNT_W)) u_word_count (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (word_inc),
    .clr   (clr),
    .count (word_count)
  );

endmodule

// File: tb/tb_lfsr_checker.sv
// Scenario bench for lfsr_checker: a reference model queues the expected outputs per driven cycle.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        clr = 1'b0;
  logic        locked;
  logic        err;
  logic [7:0]  expected;
  logic [15:0] err_count;
  logic [15:0] word_count;

  typedef struct packed {
    logic        locked;
    logic        err;
    logic [7:0]  expected;
    logic [15:0] err_count;
    logic [15:0] word_count;
  } obs_t;

  obs_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // reference model state (0 hunt, 1 verify, 2 locked)
  int          m_state;
  logic [7:0]  m_exp;
  int          m_match;
  int          m_miss;
  logic        m_locked;
  logic        m_err;
  logic [15:0] m_ec;
  logic [15:0] m_wc;

  lfsr_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .clr        (clr),
    .locked     (locked),
    .err        (err),
    .expected   (expected),
    .err_count  (err_count),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_step(input logic [7:0] x);
    logic fb;
    fb = x[7] ^ x[5] ^ x[4] ^ x[3];
    return {x[6:0], fb};
  endfunction

  function automatic obs_t get_obs();
    return {locked, err, expected, err_count, word_count};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("lk=%0b err=%0b exp=%02h ec=%0d wc=%0d", o.locked, o.err, o.expected, o.err_count, o.word_count);
  endfunction

  task automatic model_reset();
    m_state = 0; m_exp = 8'h00; m_match = 0; m_miss = 0;
    m_locked = 1'b0; m_err = 1'b0; m_ec = 16'h0; m_wc = 16'h0;
    sb.delete();
  endtask

  task automatic model_cycle(input logic v, input logic [7:0] d, input logic c);
    m_err = 1'b0;
    if (v) begin
      if (m_state == 0) begin
        if (d != 8'h00) begin
          m_exp = ref_step(d); m_match = 0; m_state = 1;
        end
      end else if (m_state == 1) begin
        if (d == m_exp) begin
          m_match++;
          m_exp = ref_step(d);
          if (m_match == 4) begin
            m_state = 2; m_locked = 1'b1; m_miss = 0;
          end
        end else if (d != 8'h00) begin
          m_exp = ref_step(d); m_match = 0;
        end else begin
          m_state = 0; m_exp = 8'h00;
        end
      end else begin
        if (m_wc != 16'hFFFF) m_wc++;
        if (d == m_exp) begin
          m_miss = 0;
          m_exp = ref_step(m_exp);
        end else begin
          m_err = 1'b1;
          if (m_ec != 16'hFFFF) m_ec++;
          m_miss++;
          m_exp = ref_step(m_exp);
          if (m_miss == 3) begin
            m_state = 0; m_locked = 1'b0; m_exp = 8'h00;
          end
        end
      end
    end
    if (c) begin
      m_ec = 16'h0; m_wc = 16'h0;
    end
    sb.push_back({m_locked, m_err, m_exp, m_ec, m_wc});
  endtask

  // Drives one cycle of stimulus starting 1 time unit after a rising edge; returns 1 unit after the next edge.
  task automatic drive(input logic v, input logic [7:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    clr      = c;
    model_cycle(v, d, c);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    clr = 1'b0;
    in_data = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t o;
    do_reset();
    o = get_obs();
    n_checks++;
    if (o !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_state: got %s, want all zero", fmt(o));
    end
  endtask

  task automatic test_acquire();
    logic [7:0] words [6];
    obs_t o, e;
    int err_seen;
    words = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    err_seen = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, words[i], 1'b0);
      e = sb.pop_front();
      o = get_obs();
      if (o.err) err_seen++;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL acquire_word%0d: got %s, want %s", i, fmt(o), fmt(e));
      end
      if (i == 3) begin
        n_checks++;
        if (locked !== 1'b0) begin
          n_fail++;
          $display("FAIL acquire_early_lock: got locked=%0b, want 0", locked);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (locked !== 1'b1) begin
          n_fail++;
          $display("FAIL acquire_lock_point: got locked=%0b, want 1", locked);
        end
      end
    end
    n_checks++;
    if (expected !== 8'h47) begin
      n_fail++;
      $display("FAIL acquire_prediction: got %02h, want 47", expected);
    end
    n_checks++;
    if (err_seen != 0) begin
      n_fail++;
      $display("FAIL acquire_no_err: got %0d pulses, want 0", err_seen);
    end
  endtask

  // Continues from the locked state left by test_acquire (next correct word is 47).
  task automatic test_single_error();
    logic [7:0] tx;
    obs_t o, e;
    int pulses;
    tx = 8'h47;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0) ? 8'h46 : tx, 1'b0);
      tx = ref_step(tx);
      e = sb.pop_front();
      o = get_obs();
      if (o.err) pulses++;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL single_err_word%0d: got %s, want %s", i, fmt(o), fmt(e));
      end
    end
    n_checks++;
    if (pulses != 1 || err_count !== 16'd1 || word_count !== 16'd5 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL single_err_summary: got pulses=%0d ec=%0d wc=%0d lk=%0b, want 1 1 5 1",
               pulses, err_count, word_count, locked);
    end
  endtask

  task automatic test_loss_of_lock();
    logic [7:0] seed [5];
    obs_t o, e;
    int pulses;
    seed = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    pulses = 0;
    do_reset();
    foreach (seed[i]) begin
      drive(1'b1, seed[i], 1'b0);
      e = sb.pop_front();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hFF, 1'b0);
      e = sb.pop_front();
      o = get_obs();
      if (o.err) pulses++;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL loss_word%0d: got %s, want %s", i, fmt(o), fmt(e));
      end
      if (i == 1) begin
        n_checks++;
        if (locked !== 1'b1) begin
          n_fail++;
          $display("FAIL loss_early_unlock: got locked=%0b, want 1", locked);
        end
      end
    end
    n_checks++;
    if (pulses != 3 || locked !== 1'b0 || err_count !== 16'd3 || expected !== 8'h00) begin
      n_fail++;
      $display("FAIL loss_summary: got pulses=%0d lk=%0b ec=%0d exp=%02h, want 3 0 3 00",
               pulses, locked, err_count, expected);
    end
    // Back in HUNT a fresh nonzero word must seed a new prediction.
    drive(1'b1, 8'h08, 1'b0);
    e = sb.pop_front();
    o = get_obs();
    n_checks++;
    if (o.expected !== 8'h11 || o.locked !== 1'b0) begin
      n_fail++;
      $display("FAIL loss_hunt_reseed: got %s, want exp=11 lk=0", fmt(o));
    end
  endtask

  task automatic test_zero_reject();
    logic [7:0] words [7];
    obs_t o, e;
    words = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    do_reset();
    foreach (words[i]) begin
      drive(1'b1, words[i], 1'b0);
      e = sb.pop_front();
      o = get_obs();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL zero_word%0d: got %s, want %s", i, fmt(o), fmt(e));
      end
      if (i == 1) begin
        n_checks++;
        if (expected !== 8'h00) begin
          n_fail++;
          $display("FAIL zero_ignored: got exp=%02h, want 00", expected);
        end
      end
    end
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_lock_point: got locked=%0b, want 1", locked);
    end
  endtask

  task automatic test_gaps_clr();
    logic [7:0] tx;
    obs_t o, e;
    int nvalid;
    tx = 8'h01;
    nvalid = 0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      if (i % 2 == 0) begin
        drive(1'b1, tx, 1'b0);
        tx = ref_step(tx);
        nvalid++;
      end else begin
        drive(1'b0, 8'($urandom_range(0, 255)), 1'b0);
      end
      e = sb.pop_front();
      o = get_obs();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL gaps_cycle%0d: got %s, want %s", i, fmt(o), fmt(e));
      end
      if (i % 2 == 0 && nvalid == 5) begin
        n_checks++;
        if (locked !== 1'b1) begin
          n_fail++;
          $display("FAIL gaps_lock_point: got locked=%0b, want 1", locked);
        end
      end
    end
    // Two counted words are in word_count now; corrupt the next and clear in the same cycle.
    drive(1'b1, ~tx, 1'b1);
    e = sb.pop_front();
    o = get_obs();
    n_checks++;
    if (o.err_count !== 16'd0 || o.word_count !== 16'd0 || o.err !== 1'b1 || o !== e) begin
      n_fail++;
      $display("FAIL clr_wins: got %s, want %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] words [7];
    obs_t o, e;
    words = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h40};
    do_reset();
    foreach (words[i]) begin
      drive(1'b1, words[i], 1'b0);
      e = sb.pop_front();
    end
    n_checks++;
    if (locked !== 1'b1 || err !== 1'b1 || word_count !== 16'd2) begin
      n_fail++;
      $display("FAIL async_pre: got %s, want lk=1 err=1 wc=2", fmt(get_obs()));
    end
    #2;
    rst_n = 1'b0;
    #1;
    o = get_obs();
    n_checks++;
    if (o !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL async_reset: got %s, want all zero", fmt(o));
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    foreach (words[i]) begin
      if (i < 5) begin
        drive(1'b1, words[i], 1'b0);
        e = sb.pop_front();
      end
    end
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reacquire: got locked=%0b, want 1", locked);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_acquire();
    test_single_error();
    test_loss_of_lock();
    test_zero_reject();
    test_gaps_clr();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive end of the team's LFSR pattern generator: consumes the 8-bit word stream the generator emits and checks it against the same Fibonacci step rule.
- Self-synchronises by seeding from received data, declares lock, then counts word errors.
- Used as the loopback/BIST sink opposite the generator, one instance per generated stream.

Parameters:
- POLY, 8'b10111000, tap mask; step(x) = {x[6:0], ^(x & POLY)}, identical to the generator.
- LOCK_CNT, 4, consecutive matching words needed to go VERIFY -> LOCKED (range 1..15).
- UNLOCK_CNT, 3, consecutive mismatching words in LOCKED that force HUNT (range 1..15).
- CNT_W, 16, width of err_count and word_count.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_data carries a word this cycle.
- in_data  in  8  received LFSR word.
- clr  in  1  synchronous clear of err_count and word_count; lock state unaffected.
- locked  out  1  registered; high while in LOCKED.
- err  out  1  one-cycle pulse: previous accepted word mismatched while LOCKED.
- expected  out  8  registered prediction for the next valid word.
- err_count  out  CNT_W  saturating count of mismatched words while LOCKED.
- word_count  out  CNT_W  saturating count of words checked while LOCKED.

Behaviour:
- Reset (rst_n low, async): state HUNT, expected=0, locked=0, err=0, err_count=0, word_count=0, match/miss counters=0.
- State changes only on cycles with in_valid=1. in_valid=0 holds all state; err is forced 0.
- Outputs are registered; the response to the word sampled at edge N appears after edge N (1-cycle latency).
- HUNT:
  - in_data==0: the all-zero lock-up word is rejected; stay in HUNT.
  - Otherwise: expected<=step(in_data), match_cnt<=0, go VERIFY.
- VERIFY:
  - in_data==expected: match_cnt++, expected<=step(in_data).
  - When match_cnt reaches LOCK_CNT: go LOCKED, locked<=1, miss_cnt<=0.
  - Mismatch, nonzero word: reseed expected<=step(in_data), match_cnt<=0, stay VERIFY.
  - Mismatch, zero word: go HUNT.
- LOCKED:
  - Every valid word: word_count++ (saturating at all-ones).
  - Match: miss_cnt<=0.
  - Mismatch: err<=1, err_count++ (saturating), miss_cnt++.
  - expected<=step(expected): freewheel on the prediction, not the received word, so one corrupted word yields exactly one error.
  - When miss_cnt reaches UNLOCK_CNT: go HUNT, locked<=0, expected<=0. Counters keep their values.
- clr in the same cycle as a counted word: clear wins; counters read 0 afterwards.
- Counters saturate; they never wrap.
- Reset asserted mid-stream: immediate return to the reset values. Re-acquire needs 1 seed word + LOCK_CNT matching words.

Decomposition:
- Shared package (also imported by the generator): the step function lfsr_step(x, poly), default POLY constant, and a state enum {HUNT, VERIFY, LOCKED} for the checker.
- One natural sub-module: sat_counter (CNT_W, inc, clr, saturating), instantiated for err_count and word_count.
- Everything else stays in lfsr_checker.

Test Plan:
- Acquire: POLY=8'hB8, feed 01,02,04,08,11,23 contiguously -> locked rises after the 5th word; expected=8'h47 after the 6th; err never asserts.
- Single error: after lock feed 47 as 46, then the correct continuation -> exactly one err pulse; err_count=1; word_count increments every word; locked stays 1.
- Loss of lock: after lock feed three words of 8'hFF -> err pulses 3 times; locked falls after the 3rd; state returns to HUNT; err_count=3.
- Zero rejection: in HUNT feed 00,00 then 01,02,04,08,11 -> 00 words ignored, lock achieved on 11.
- Gaps and clr: lock with in_valid toggling 1/0 each cycle -> same lock point as contiguous feed. Pulse clr with a counted word -> both counters read 0 next cycle.
- Async reset: drop rst_n mid-cycle while LOCKED -> locked, err, and the counters go 0 without waiting for a clk edge.
